alu_writeback_ctrl: RTL and testbench
=====================================

// Module: alu_writeback_ctrl
// PURPOSE
//  Sequencer and ALU stage downstream of the 16x16 register file.
//  - Accepts one instruction per valid/ready handshake.
//  - Drives the register-file read addresses and registers both operands.
//  - Computes the result and flags, then writes back through the regfile's En/Load port.
//  - Multicycle and non-pipelined: one instruction in flight.
// PARAMETERS
//  WIDTH  16  datapath width; must match the regfile word (16 is the only supported value)
//  IMM_W  8   immediate field width
// PORTS
//  Clk          in   1      rising-edge clock
//  Rst          in   1      asynchronous, active-low reset
//  InstValid    in   1      instruction present on Opcode/RdestLoc/RsrcLoc/Imm/UseImm
//  InstReady    out  1      block can accept (high only in IDLE)
//  Opcode       in   4      operation, see BEHAVIOUR
//  RdestLoc     in   4      destination / first-operand register
//  RsrcLoc      in   4      source register
//  Imm          in   IMM_W  immediate value
//  UseImm       in   1      1: the immediate replaces the Rsrc operand
//  RdestRegLoc  out  4      to regfile RdestRegLoc (read A and write address)
//  RsrcRegLoc   out  4      to regfile RsrcRegLoc
//  RdestData    in   WIDTH  from regfile RdestOut
//  RsrcData     in   WIDTH  from regfile RsrcOut
//  WrEn         out  1      to regfile En
//  WrData       out  WIDTH  to regfile Load
//  Flags        out  5      {C,F,L,Z,N} status register
//  Done         out  1      one-cycle pulse when the instruction retires
// BEHAVIOUR
//  Reset (Rst=0, asynchronous):
//  - State goes to IDLE.
//  - All outputs are 0 except InstReady, which is 1.
//  - Reset mid-instruction aborts it. No WrEn is issued afterwards.
//  States: IDLE -> READ -> EXEC -> WB -> IDLE
//  - IDLE: InstReady=1. On InstValid, latch Opcode, locations, Imm and UseImm; go to READ.
//  - READ: drive the latched locations onto RdestRegLoc/RsrcRegLoc; register RdestData/RsrcData.
//  - EXEC: compute the result and new flags; register them.
//  - WB: WrEn=1 for one cycle if the opcode writes; Done=1 (always); next state IDLE.
//  Timing:
//  - Handshake accepted at edge T. WrEn and Done are high during cycle T+3.
//  - The next instruction can be accepted at edge T+4.
//  - InstValid during READ/EXEC/WB is ignored. The instruction is not queued.
//  Address outputs:
//  - RdestRegLoc holds the latched destination from READ through WB.
//  - RdestRegLoc and RsrcRegLoc hold their last values in IDLE.
//  Operand B:
//  - UseImm=1: Imm sign-extended for ADD/SUB/CMP/MOV; zero-extended for AND/OR/XOR.
//  - UseImm=0: RsrcData.
//  Opcodes (A = Rdest value, B = operand B):
//  - 0000 ADD: A+B
//  - 0001 SUB: A-B
//  - 0010 CMP: no write
//  - 0011 AND
//  - 0100 OR
//  - 0101 XOR
//  - 0110 MOV: B
//  - 0111 LSH: B[4]=0 shifts A left by B[3:0]; B[4]=1 shifts A logically right by B[3:0]
//  - 1000 LUI: {Imm,8'h00}
//  - 1001-1111 NOP: no write; flags unchanged; Done still pulses.
//  Flag updates (flags not listed keep their value):
//  - ADD: C = unsigned carry-out; F = signed overflow.
//  - SUB: C = borrow (A<B unsigned); F = signed overflow.
//  - CMP: L = (A<B unsigned); Z = (A==B); N = (A<B signed). C and F unchanged.
//  - Logic, MOV, LSH and LUI leave Flags unchanged.
//  Arithmetic: results wrap modulo 2^WIDTH. A shift of 0 passes A unchanged.
//  Same-register instructions: Rdest==Rsrc is legal and both operands read the same value.
//  Flags register: updates at the EXEC->WB edge and holds until the next flag-setting op or reset.
// TESTING
//  1. Load path: MOV R3,#-2 (UseImm) -> WrEn in cycle T+3, RdestRegLoc=3, WrData=16'hFFFE, Done=1.
//  2. ADD overflow: R1=16'h7FFF, R2=16'h0001, ADD R1,R2 -> WrData=16'h8000, F=1, C=0.
//     Then ADD 16'hFFFF+1 -> WrData=0, C=1, F=0.
//  3. CMP R4=5, R5=16'hFFFF -> L=1, N=0, Z=0, WrEn stays 0, Done pulses, C and F unchanged.
//  4. LSH: A=16'h0001, B=5'b00100 -> WrData=16'h0010.
//     Then A=16'h8000, B=5'b10011 -> WrData=16'h1000.
//  5. Busy: second InstValid at T+1 is ignored (InstReady=0). It is accepted only when re-presented at T+4.
//  6. Reset: drop Rst in EXEC -> immediately WrEn=0, Flags=0, InstReady=1, and no writeback on later edges.

Source files
------------

// File: rtl/alu_writeback_ctrl.sv
// Multicycle ALU sequencer sitting downstream of the 16x16 register file.
// One instruction in flight: IDLE -> READ -> EXEC -> WB, then writeback via the regfile En/Load port.
module alu_writeback_ctrl #(
  parameter int WIDTH = 16,
  parameter int IMM_W = 8
) (
  input  logic             Clk,
  input  logic             Rst,
  input  logic             InstValid,
  output logic             InstReady,
  input  logic [3:0]       Opcode,
  input  logic [3:0]       RdestLoc,
  input  logic [3:0]       RsrcLoc,
  input  logic [IMM_W-1:0] Imm,
  input  logic             UseImm,
  output logic [3:0]       RdestRegLoc,
  output logic [3:0]       RsrcRegLoc,
  input  logic [WIDTH-1:0] RdestData,
  input  logic [WIDTH-1:0] RsrcData,
  output logic             WrEn,
  output logic [WIDTH-1:0] WrData,
  output logic [4:0]       Flags,
  output logic             Done
);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_READ = 2'd1;
  localparam logic [1:0] S_EXEC = 2'd2;
  localparam logic [1:0] S_WB   = 2'd3;

  localparam logic [3:0] OP_ADD = 4'b0000;
  localparam logic [3:0] OP_SUB = 4'b0001;
  localparam logic [3:0] OP_CMP = 4'b0010;
  localparam logic [3:0] OP_AND = 4'b0011;
  localparam logic [3:0] OP_OR  = 4'b0100;
  localparam logic [3:0] OP_XOR = 4'b0101;
  localparam logic [3:0] OP_MOV = 4'b0110;
  localparam logic [3:0] OP_LSH = 4'b0111;
  localparam logic [3:0] OP_LUI = 4'b1000;

  // Flags bit positions: {C,F,L,Z,N}
  localparam int unsigned FC = 4;
  localparam int unsigned FF = 3;
  localparam int unsigned FL = 2;
  localparam int unsigned FZ = 1;
  localparam int unsigned FN = 0;

  logic [1:0]       state;
  logic [3:0]       op_q;
  logic [3:0]       dloc_q;
  logic [3:0]       sloc_q;
  logic [IMM_W-1:0] imm_q;
  logic             useimm_q;
  logic [WIDTH-1:0] a_q;
  logic [WIDTH-1:0] b_q;
  logic [WIDTH-1:0] res_q;
  logic             wr_q;
  logic [4:0]       flags_q;

  logic [WIDTH-1:0] imm_sx;
  logic [WIDTH-1:0] imm_zx;
  logic [WIDTH-1:0] opb;
  logic [WIDTH:0]   sum;
  logic [WIDTH:0]   diff;
  logic [WIDTH-1:0] result;
  logic             writes;
  logic [4:0]       flags_nx;
  logic             sign_ext_op;

  always_comb begin
    imm_sx      = {{(WIDTH-IMM_W){imm_q[IMM_W-1]}}, imm_q};
    imm_zx      = {{(WIDTH-IMM_W){1'b0}}, imm_q};
    sign_ext_op = (op_q == OP_ADD) || (op_q == OP_SUB) ||
                  (op_q == OP_CMP) || (op_q == OP_MOV);
    opb         = useimm_q ? (sign_ext_op ? imm_sx : imm_zx) : b_q;
    sum         = {1'b0, a_q} + {1'b0, opb};
    // MSB of the widened difference is the unsigned borrow (A < B)
    diff        = {1'b0, a_q} - {1'b0, opb};
    result      = '0;
    writes      = 1'b0;
    flags_nx    = flags_q;
    case (op_q)
      OP_ADD: begin
        result       = sum[WIDTH-1:0];
        writes       = 1'b1;
        flags_nx[FC] = sum[WIDTH];
        flags_nx[FF] = (a_q[WIDTH-1] == opb[WIDTH-1]) && (sum[WIDTH-1] != a_q[WIDTH-1]);
      end
      OP_SUB: begin
        result       = diff[WIDTH-1:0];
        writes       = 1'b1;
        flags_nx[FC] = diff[WIDTH];
        flags_nx[FF] = (a_q[WIDTH-1] != opb[WIDTH-1]) && (diff[WIDTH-1] != a_q[WIDTH-1]);
      end
      OP_CMP: begin
        flags_nx[FL] = diff[WIDTH];
        flags_nx[FZ] = (a_q == opb);
        flags_nx[FN] = ($signed(a_q) < $signed(opb));
      end
      OP_AND: begin result = a_q & opb; writes = 1'b1; end
      OP_OR:  begin result = a_q | opb; writes = 1'b1; end
      OP_XOR: begin result = a_q ^ opb; writes = 1'b1; end
      OP_MOV: begin result = opb;       writes = 1'b1; end
      OP_LSH: begin
        result = opb[4] ? (a_q >> opb[3:0]) : (a_q << opb[3:0]);
        writes = 1'b1;
      end
      OP_LUI: begin
        result = {imm_q, {(WIDTH-IMM_W){1'b0}}};
        writes = 1'b1;
      end
      default: ;
    endcase
  end

  always_ff @(posedge Clk or negedge Rst) begin
    if (!Rst) begin
      state    <= S_IDLE;
      op_q     <= '0;
      dloc_q   <= '0;
      sloc_q   <= '0;
      imm_q    <= '0;
      useimm_q <= 1'b0;
      a_q      <= '0;
      b_q      <= '0;
      res_q    <= '0;
      wr_q     <= 1'b0;
      flags_q  <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (InstValid) begin
            op_q     <= Opcode;
            dloc_q   <= RdestLoc;
            sloc_q   <= RsrcLoc;
            imm_q    <= Imm;
            useimm_q <= UseImm;
            state    <= S_READ;
          end
        end
        S_READ: begin
          a_q   <= RdestData;
          b_q   <= RsrcData;
          state <= S_EXEC;
        end
        S_EXEC: begin
          res_q   <= result;
          wr_q    <= writes;
          flags_q <= flags_nx;
          state   <= S_WB;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  assign InstReady   = (state == S_IDLE);
  assign RdestRegLoc = dloc_q;
  assign RsrcRegLoc  = sloc_q;
  assign WrData      = res_q;
  assign WrEn        = (state == S_WB) && wr_q;
  assign Done        = (state == S_WB);
  assign Flags       = flags_q;

endmodule

// File: tb/tb_alu_writeback_ctrl.sv
// Directed bench for alu_writeback_ctrl with a behavioural 16x16 register file attached.
module tb_alu_writeback_ctrl;

  logic        Clk = 1'b0;
  logic        Rst;
  logic        InstValid;
  logic        InstReady;
  logic [3:0]  Opcode;
  logic [3:0]  RdestLoc;
  logic [3:0]  RsrcLoc;
  logic [7:0]  Imm;
  logic        UseImm;
  logic [3:0]  RdestRegLoc;
  logic [3:0]  RsrcRegLoc;
  logic [15:0] RdestData;
  logic [15:0] RsrcData;
  logic        WrEn;
  logic [15:0] WrData;
  logic [4:0]  Flags;
  logic        Done;

  logic [15:0] regs [16];
  logic        pk_en = 1'b0;
  logic [3:0]  pk_idx = '0;
  logic [15:0] pk_val = '0;

  int nchk = 0;
  int nerr = 0;

  alu_writeback_ctrl #(.WIDTH(16), .IMM_W(8)) dut (
    .Clk(Clk), .Rst(Rst), .InstValid(InstValid), .InstReady(InstReady),
    .Opcode(Opcode), .RdestLoc(RdestLoc), .RsrcLoc(RsrcLoc), .Imm(Imm), .UseImm(UseImm),
    .RdestRegLoc(RdestRegLoc), .RsrcRegLoc(RsrcRegLoc),
    .RdestData(RdestData), .RsrcData(RsrcData),
    .WrEn(WrEn), .WrData(WrData), .Flags(Flags), .Done(Done)
  );

  always #5 Clk = ~Clk;

  assign RdestData = regs[RdestRegLoc];
  assign RsrcData  = regs[RsrcRegLoc];

  always @(posedge Clk) begin
    if (pk_en) regs[pk_idx] <= pk_val;
    else if (WrEn) regs[RdestRegLoc] <= WrData;
  end

  task automatic poke(input logic [3:0] idx, input logic [15:0] val);
    @(negedge Clk);
    pk_idx = idx; pk_val = val; pk_en = 1'b1;
    @(posedge Clk);
    #1 pk_en = 1'b0;
  endtask

  // Present an instruction and return #1 after the accepting edge (DUT in READ).
  task automatic send(input logic [3:0] op, input logic [3:0] d, input logic [3:0] s,
                      input logic [7:0] imm, input logic ui);
    @(negedge Clk);
    Opcode = op; RdestLoc = d; RsrcLoc = s; Imm = imm; UseImm = ui; InstValid = 1'b1;
    @(posedge Clk);
    #1 InstValid = 1'b0;
  endtask

  task automatic to_wb();
    @(posedge Clk); @(posedge Clk); #1;
  endtask

  task automatic to_idle();
    @(posedge Clk); #1;
  endtask

  task automatic test_reset();
    Rst = 1'b0; InstValid = 1'b0; Opcode = '0; RdestLoc = '0; RsrcLoc = '0; Imm = '0; UseImm = 1'b0;
    #12;
    nchk++; if (InstReady !== 1'b1) begin nerr++; $display("FAIL reset_ready: got %b exp 1", InstReady); end
    nchk++; if (WrEn !== 1'b0) begin nerr++; $display("FAIL reset_wren: got %b exp 0", WrEn); end
    nchk++; if (Done !== 1'b0) begin nerr++; $display("FAIL reset_done: got %b exp 0", Done); end
    nchk++; if (Flags !== 5'b00000) begin nerr++; $display("FAIL reset_flags: got %b exp 00000", Flags); end
    nchk++; if (WrData !== 16'h0000) begin nerr++; $display("FAIL reset_wrdata: got %h exp 0000", WrData); end
    nchk++; if ({RdestRegLoc, RsrcRegLoc} !== 8'h00) begin nerr++; $display("FAIL reset_locs: got %h exp 00", {RdestRegLoc, RsrcRegLoc}); end
    @(negedge Clk); Rst = 1'b1;
  endtask

  task automatic test_load_path();
    send(4'b0110, 4'd3, 4'd0, 8'hFE, 1'b1);
    @(posedge Clk); #1;
    nchk++; if ({WrEn, Done} !== 2'b00) begin nerr++; $display("FAIL load_early: got %b exp 00", {WrEn, Done}); end
    @(posedge Clk); #1;
    nchk++; if (WrEn !== 1'b1) begin nerr++; $display("FAIL load_wren: got %b exp 1", WrEn); end
    nchk++; if (RdestRegLoc !== 4'd3) begin nerr++; $display("FAIL load_loc: got %0d exp 3", RdestRegLoc); end
    nchk++; if (WrData !== 16'hFFFE) begin nerr++; $display("FAIL load_data: got %h exp fffe", WrData); end
    nchk++; if (Done !== 1'b1) begin nerr++; $display("FAIL load_done: got %b exp 1", Done); end
    nchk++; if (Flags !== 5'b00000) begin nerr++; $display("FAIL load_flags: got %b exp 00000", Flags); end
    to_idle();
    nchk++; if (regs[3] !== 16'hFFFE) begin nerr++; $display("FAIL load_reg: got %h exp fffe", regs[3]); end
    nchk++; if ({InstReady, WrEn, Done} !== 3'b100) begin nerr++; $display("FAIL load_after: got %b exp 100", {InstReady, WrEn, Done}); end
  endtask

  task automatic test_add_overflow();
    poke(4'd1, 16'h7FFF); poke(4'd2, 16'h0001);
    send(4'b0000, 4'd1, 4'd2, 8'h00, 1'b0); to_wb();
    nchk++; if (WrData !== 16'h8000) begin nerr++; $display("FAIL add_ovf_data: got %h exp 8000", WrData); end
    nchk++; if (Flags !== 5'b01000) begin nerr++; $display("FAIL add_ovf_flags: got %b exp 01000", Flags); end
    to_idle();
    poke(4'd6, 16'hFFFF); poke(4'd7, 16'h0001);
    send(4'b0000, 4'd6, 4'd7, 8'h00, 1'b0); to_wb();
    nchk++; if (WrData !== 16'h0000) begin nerr++; $display("FAIL add_carry_data: got %h exp 0000", WrData); end
    nchk++; if (Flags !== 5'b10000) begin nerr++; $display("FAIL add_carry_flags: got %b exp 10000", Flags); end
    to_idle();
  endtask

  task automatic test_cmp();
    poke(4'd4, 16'h0005); poke(4'd5, 16'hFFFF);
    send(4'b0010, 4'd4, 4'd5, 8'h00, 1'b0); to_wb();
    nchk++; if (Flags !== 5'b10100) begin nerr++; $display("FAIL cmp_flags: got %b exp 10100", Flags); end
    nchk++; if ({WrEn, Done} !== 2'b01) begin nerr++; $display("FAIL cmp_ctrl: got %b exp 01", {WrEn, Done}); end
    to_idle();
    nchk++; if (regs[4] !== 16'h0005) begin nerr++; $display("FAIL cmp_nowrite: got %h exp 0005", regs[4]); end
  endtask

  task automatic test_sub();
    poke(4'd8, 16'h8000); poke(4'd9, 16'h0001);
    send(4'b0001, 4'd8, 4'd9, 8'h00, 1'b0); to_wb();
    nchk++; if (WrData !== 16'h7FFF) begin nerr++; $display("FAIL sub_data: got %h exp 7fff", WrData); end
    nchk++; if (Flags !== 5'b01100) begin nerr++; $display("FAIL sub_flags: got %b exp 01100", Flags); end
    to_idle();
    send(4'b0001, 4'd9, 4'd9, 8'h03, 1'b1); to_wb();
    nchk++; if (WrData !== 16'hFFFE) begin nerr++; $display("FAIL sub_imm_data: got %h exp fffe", WrData); end
    nchk++; if (Flags !== 5'b10100) begin nerr++; $display("FAIL sub_borrow_flags: got %b exp 10100", Flags); end
    to_idle();
  endtask

  task automatic test_logic();
    poke(4'd10, 16'hF0F0);
    send(4'b0011, 4'd10, 4'd0, 8'hFF, 1'b1); to_wb();
    nchk++; if (WrData !== 16'h00F0) begin nerr++; $display("FAIL and_imm: got %h exp 00f0", WrData); end
    to_idle();
    send(4'b0110, 4'd11, 4'd0, 8'h7F, 1'b1); to_wb(); to_idle();
    send(4'b1000, 4'd12, 4'd0, 8'hAB, 1'b1); to_wb();
    nchk++; if (WrData !== 16'hAB00) begin nerr++; $display("FAIL lui: got %h exp ab00", WrData); end
    to_idle();
    send(4'b0100, 4'd12, 4'd0, 8'h80, 1'b1); to_wb();
    nchk++; if (WrData !== 16'hAB80) begin nerr++; $display("FAIL or_zext: got %h exp ab80", WrData); end
    to_idle();
    send(4'b0101, 4'd10, 4'd11, 8'h00, 1'b0); to_wb();
    nchk++; if (WrData !== 16'h008F) begin nerr++; $display("FAIL xor_reg: got %h exp 008f", WrData); end
    nchk++; if (Flags !== 5'b10100) begin nerr++; $display("FAIL logic_flags: got %b exp 10100", Flags); end
    to_idle();
  endtask

  task automatic test_lsh();
    poke(4'd13, 16'h0001); poke(4'd14, 16'h0004);
    send(4'b0111, 4'd13, 4'd14, 8'h00, 1'b0); to_wb();
    nchk++; if (WrData !== 16'h0010) begin nerr++; $display("FAIL lsh_left: got %h exp 0010", WrData); end
    to_idle();
    poke(4'd13, 16'h8000); poke(4'd14, 16'h0013);
    send(4'b0111, 4'd13, 4'd14, 8'h00, 1'b0); to_wb();
    nchk++; if (WrData !== 16'h1000) begin nerr++; $display("FAIL lsh_right: got %h exp 1000", WrData); end
    to_idle();
    poke(4'd14, 16'h0000);
    send(4'b0111, 4'd13, 4'd14, 8'h00, 1'b0); to_wb();
    nchk++; if (WrData !== 16'h1000) begin nerr++; $display("FAIL lsh_zero: got %h exp 1000", WrData); end
    to_idle();
  endtask

  task automatic test_same_reg();
    poke(4'd15, 16'h0003);
    send(4'b0000, 4'd15, 4'd15, 8'h00, 1'b0); to_wb();
    nchk++; if (WrData !== 16'h0006) begin nerr++; $display("FAIL same_add: got %h exp 0006", WrData); end
    nchk++; if (Flags !== 5'b00100) begin nerr++; $display("FAIL same_add_flags: got %b exp 00100", Flags); end
    to_idle();
    send(4'b0010, 4'd15, 4'd15, 8'h00, 1'b0); to_wb();
    nchk++; if (Flags !== 5'b00010) begin nerr++; $display("FAIL same_cmp_flags: got %b exp 00010", Flags); end
    to_idle();
  endtask

  task automatic test_nop();
    send(4'b1010, 4'd15, 4'd1, 8'h55, 1'b1); to_wb();
    nchk++; if ({WrEn, Done} !== 2'b01) begin nerr++; $display("FAIL nop_ctrl: got %b exp 01", {WrEn, Done}); end
    nchk++; if (Flags !== 5'b00010) begin nerr++; $display("FAIL nop_flags: got %b exp 00010", Flags); end
    to_idle();
    nchk++; if (regs[15] !== 16'h0006) begin nerr++; $display("FAIL nop_nowrite: got %h exp 0006", regs[15]); end
  endtask

  task automatic test_back_to_back();
    send(4'b0110, 4'd1, 4'd0, 8'h05, 1'b1);
    @(negedge Clk);
    Opcode = 4'b0110; RdestLoc = 4'd2; RsrcLoc = 4'd0; Imm = 8'h09; UseImm = 1'b1; InstValid = 1'b1;
    nchk++; if (InstReady !== 1'b0) begin nerr++; $display("FAIL busy_ready: got %b exp 0", InstReady); end
    @(posedge Clk); #1 InstValid = 1'b0;
    @(posedge Clk); #1;
    nchk++; if ({WrEn, RdestRegLoc, WrData} !== {1'b1, 4'd1, 16'h0005}) begin
      nerr++; $display("FAIL busy_first: got %h exp 1_1_0005", {WrEn, RdestRegLoc, WrData});
    end
    to_idle();
    nchk++; if ({InstReady, regs[2]} !== {1'b1, 16'h0001}) begin
      nerr++; $display("FAIL busy_ignored: got %h exp 1_0001", {InstReady, regs[2]});
    end
    send(4'b0110, 4'd2, 4'd0, 8'h09, 1'b1); to_wb();
    nchk++; if ({WrEn, RdestRegLoc, WrData} !== {1'b1, 4'd2, 16'h0009}) begin
      nerr++; $display("FAIL busy_second: got %h exp 1_2_0009", {WrEn, RdestRegLoc, WrData});
    end
    to_idle();
  endtask

  task automatic test_reset_mid();
    int bad;
    bad = 0;
    send(4'b0000, 4'd1, 4'd1, 8'h00, 1'b0);
    @(posedge Clk); #1;
    Rst = 1'b0;
    #1;
    nchk++; if ({WrEn, Done, InstReady} !== 3'b001) begin nerr++; $display("FAIL rst_mid_ctrl: got %b exp 001", {WrEn, Done, InstReady}); end
    nchk++; if (Flags !== 5'b00000) begin nerr++; $display("FAIL rst_mid_flags: got %b exp 00000", Flags); end
    @(negedge Clk); Rst = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(posedge Clk); #1;
      if (WrEn !== 1'b0 || Done !== 1'b0) bad++;
    end
    nchk++; if (bad != 0) begin nerr++; $display("FAIL rst_mid_nowb: got %0d strobes exp 0", bad); end
    nchk++; if (regs[1] !== 16'h0005) begin nerr++; $display("FAIL rst_mid_reg: got %h exp 0005", regs[1]); end
  endtask

  initial begin
    test_reset();
    test_load_path();
    test_add_overflow();
    test_cmp();
    test_sub();
    test_logic();
    test_lsh();
    test_same_reg();
    test_nop();
    test_back_to_back();
    test_reset_mid();
    $display("Result: errors=%0d of %0d checks", nerr, nchk);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

endmodule
